// File: rtl/vdc_pkg.sv
// Shared types and default sizing for the HuC6270 VDC self-test slice.
// Holds the test FSM state encoding and the memory widths/test pattern defaults.
package vdc_pkg;

    localparam int VDC_BRAM_AW = 15;
    localparam int VDC_VRAM_AW = 16;
    localparam int VDC_DW      = 16;

    localparam logic [15:0] VDC_TEST_PATTERN = 16'hF0F0;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_END   = 2'd3
    } vdc_state_e;

endpackage

// File: rtl/vdc_huc6270_if.sv
// Single-port memory bus: address, write enable, write data and read data.
// master drives the request side, slave returns registered read data.
interface vdc_huc6270_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/vdc_sync_ram.sv
// Generic synchronous single-port RAM, one-cycle read latency.
// Read-during-write returns the old word; contents are never reset.
module vdc_sync_ram #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic            clk,
    vdc_huc6270_if.slave    mem_if
);

    logic [DW-1:0] mem [0:(1 << AW)-1];
    logic [DW-1:0] rdata_d;
    logic [DW-1:0] rdata_q;

    // Sampled before the write lands, which gives read-old-data behaviour.
    always_comb begin
        rdata_d = mem[mem_if.addr];
    end

    always_ff @(posedge clk) begin
        if (mem_if.we) begin
            mem[mem_if.addr] <= mem_if.wdata;
        end
        rdata_q <= rdata_d;
    end

    assign mem_if.rdata = rdata_q;

endmodule

// File: rtl/vdc_huc6270.sv
// HuC6270 VDC skeleton: free-running VRAM address unit plus a BRAM write/read self-test.
// The FSM writes TEST_PATTERN once after reset, reads it back, then parks in END.
module vdc_huc6270
    import vdc_pkg::*;
#(
    parameter int              BRAM_AW      = VDC_BRAM_AW,
    parameter int              VRAM_AW      = VDC_VRAM_AW,
    parameter int              DW           = VDC_DW,
    parameter logic [DW-1:0]   TEST_PATTERN = VDC_TEST_PATTERN,
    parameter int              TEST_ADDR    = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        D,
    output logic [1:0]         state,
    output logic [DW-1:0]      data_out,
    output logic [VRAM_AW-1:0] MA
);

    vdc_state_e         state_q, state_d;
    logic [VRAM_AW-1:0] ma_q, ma_d;

    vdc_huc6270_if #(.AW(VRAM_AW), .DW(DW)) vram_if ();
    vdc_huc6270_if #(.AW(BRAM_AW), .DW(DW)) bram_if ();

    // The CPU bus and the VRAM read port have no consumer yet.
    logic d_unused;
    logic md_out_unused;
    assign d_unused      = ^D;
    assign md_out_unused = ^vram_if.rdata;

    always_comb begin
        ma_d = ma_q + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:  state_d = ST_WRITE;
            ST_WRITE: state_d = ST_READ;
            ST_READ:  state_d = ST_END;
            ST_END:   state_d = ST_END;
            default:  state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_WAIT;
            ma_q    <= '0;
        end else begin
            state_q <= state_d;
            ma_q    <= ma_d;
        end
    end

    // Write is gated by reset so a held reset never rewrites the test word.
    always_comb begin
        bram_if.addr  = BRAM_AW'(TEST_ADDR);
        bram_if.we    = 1'b0;
        bram_if.wdata = '0;
        if (state_q == ST_WAIT && !reset) begin
            bram_if.we    = 1'b1;
            bram_if.wdata = TEST_PATTERN;
        end
    end

    always_comb begin
        vram_if.addr  = ma_q;
        vram_if.we    = 1'b0;
        vram_if.wdata = '0;
    end

    vdc_sync_ram #(.AW(VRAM_AW), .DW(DW)) u_vram (
        .clk    (clock),
        .mem_if (vram_if)
    );

    vdc_sync_ram #(.AW(BRAM_AW), .DW(DW)) u_bram (
        .clk    (clock),
        .mem_if (bram_if)
    );

    assign state    = state_q;
    assign data_out = bram_if.rdata;
    assign MA       = ma_q;

endmodule

// File: tb/tb_vdc_huc6270.sv
// Self-checking bench for vdc_huc6270 against a cycle-count reference model.
// Also exercises the generic RAM standalone through the memory-bus interface.
module tb_vdc_huc6270;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] D;
    logic [1:0]  state;
    logic [15:0] data_out;
    logic [15:0] MA;

    always #5 clock = ~clock;

    vdc_huc6270 dut (
        .clock    (clock),
        .reset    (reset),
        .D        (D),
        .state    (state),
        .data_out (data_out),
        .MA       (MA)
    );

    vdc_huc6270_if #(.AW(4), .DW(16)) ram_bus ();
    vdc_sync_ram #(.AW(4), .DW(16)) u_ram (
        .clk    (clock),
        .mem_if (ram_bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: n = clock edges since the last edge seen with reset high;
    // writes = number of completed pattern writes; pat_before = memory held
    // the pattern just before the most recent edge.
    int n = 0;
    int writes = 0;
    bit pat_before = 1'b0;

    localparam logic [15:0] PAT = 16'hF0F0;

    function automatic logic [1:0] exp_state(input int k);
        return (k >= 3) ? 2'd3 : 2'(k);
    endfunction

    task automatic step(input logic r, input logic [15:0] d);
        reset = r;
        D     = d;
        pat_before = (writes > 0);
        @(posedge clock);
        #1;
        if (r) begin
            n = 0;
        end else begin
            if (n == 0) writes++;
            n++;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 16'($urandom));
            total++;
            if (state !== 2'd0) begin
                bad++; $display("FAIL reset_state cyc=%0d got=%0d want=0", i, state);
            end
            total++;
            if (MA !== 16'h0000) begin
                bad++; $display("FAIL reset_ma cyc=%0d got=%h want=0000", i, MA);
            end
        end
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 16'h0000);
            total++;
            if (state !== exp_state(n)) begin
                bad++; $display("FAIL seq_state n=%0d got=%0d want=%0d", n, state, exp_state(n));
            end
            total++;
            if (MA !== 16'(n)) begin
                bad++; $display("FAIL seq_ma n=%0d got=%h want=%h", n, MA, 16'(n));
            end
            if (pat_before) begin
                total++;
                if (data_out !== PAT) begin
                    bad++; $display("FAIL seq_dout n=%0d got=%h want=%h", n, data_out, PAT);
                end
            end else begin
                total++;
                if (data_out === PAT) begin
                    bad++; $display("FAIL seq_old_data n=%0d got=%h want=not %h", n, data_out, PAT);
                end
            end
        end
    endtask

    task automatic test_ma_wrap();
        int guard = 0;
        while (16'(n) != 16'hFFFF && guard < 70000) begin
            step(1'b0, 16'h0000);
            guard++;
        end
        total++;
        if (MA !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_top got=%h want=ffff guard=%0d", MA, guard);
        end
        step(1'b0, 16'h0000);
        total++;
        if (MA !== 16'h0000) begin
            bad++; $display("FAIL wrap_zero got=%h want=0000", MA);
        end
        total++;
        if (state !== 2'd3) begin
            bad++; $display("FAIL wrap_state got=%0d want=3", state);
        end
    endtask

    task automatic test_reset_in_end();
        step(1'b1, 16'h0000);
        total++;
        if (state !== 2'd0) begin
            bad++; $display("FAIL end_rst_state got=%0d want=0", state);
        end
        total++;
        if (MA !== 16'h0000) begin
            bad++; $display("FAIL end_rst_ma got=%h want=0000", MA);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 16'h0000);
            total++;
            if (state !== exp_state(i)) begin
                bad++; $display("FAIL end_rst_seq n=%0d got=%0d want=%0d", i, state, exp_state(i));
            end
            if (i >= 2) begin
                total++;
                if (data_out !== PAT) begin
                    bad++; $display("FAIL end_rst_dout n=%0d got=%h want=%h", i, data_out, PAT);
                end
            end
        end
    endtask

    task automatic test_d_independence();
        logic [1:0]  st_a [12];
        logic [15:0] do_a [12];
        logic [15:0] ma_a [12];
        step(1'b1, 16'h0000);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'h0000);
            st_a[i] = state; do_a[i] = data_out; ma_a[i] = MA;
        end
        step(1'b1, 16'($urandom));
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 16'($urandom));
            total++;
            if (state !== st_a[i]) begin
                bad++; $display("FAIL d_state cyc=%0d got=%0d want=%0d", i, state, st_a[i]);
            end
            total++;
            if (data_out !== do_a[i]) begin
                bad++; $display("FAIL d_dout cyc=%0d got=%h want=%h", i, data_out, do_a[i]);
            end
            total++;
            if (MA !== ma_a[i]) begin
                bad++; $display("FAIL d_ma cyc=%0d got=%h want=%h", i, MA, ma_a[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 16'($urandom));
            total++;
            if (state !== exp_state(n)) begin
                bad++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", i, state, exp_state(n));
            end
            total++;
            if (MA !== 16'(n)) begin
                bad++; $display("FAIL rnd_ma cyc=%0d got=%h want=%h", i, MA, 16'(n));
            end
            if (pat_before) begin
                total++;
                if (data_out !== PAT) begin
                    bad++; $display("FAIL rnd_dout cyc=%0d got=%h want=%h", i, data_out, PAT);
                end
            end
        end
    endtask

    task automatic test_ram_rdw();
        logic [15:0] model [16];
        logic [15:0] exp_v;
        for (int a = 0; a < 16; a++) begin
            ram_bus.addr  = 4'(a);
            ram_bus.we    = 1'b1;
            ram_bus.wdata = 16'($urandom);
            model[a]      = ram_bus.wdata;
            @(posedge clock); #1;
        end
        for (int i = 0; i < 40; i++) begin
            ram_bus.addr  = 4'($urandom_range(0, 15));
            ram_bus.we    = 1'($urandom_range(0, 1));
            ram_bus.wdata = 16'($urandom);
            exp_v = model[ram_bus.addr];
            @(posedge clock); #1;
            total++;
            if (ram_bus.rdata !== exp_v) begin
                bad++; $display("FAIL ram_rdw op=%0d addr=%0d got=%h want=%h", i, ram_bus.addr, ram_bus.rdata, exp_v);
            end
            if (ram_bus.we) model[ram_bus.addr] = ram_bus.wdata;
        end
        ram_bus.we = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        D     = 16'h0000;
        ram_bus.addr  = '0;
        ram_bus.we    = 1'b0;
        ram_bus.wdata = '0;
        test_reset();
        test_sequence();
        test_ma_wrap();
        test_reset_in_end();
        test_d_independence();
        test_random();
        test_ram_rdw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
